pe_host_sequencer: RTL and testbench

Autonomous host-side sequencer for the PE system (pe_top). On a single start command it performs the full convolution job:
- streams weight and activation vectors from a 128-bit valid/ready input into the weight and activation buffers;
- programs the PE config registers, issues start, and polls status until done;
- drains the psum buffer to a 512-bit valid/ready output stream.

It replaces the manual load/configure/poll/read sequence the host currently performs.

---
 rtl/pe_seq_pkg.sv | 27 ++
 rtl/pe_seq_addr_gen.sv | 54 +++++
 rtl/pe_host_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_pe_host_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE host sequencer: FSM states, PE config
// register map and stream lane geometry.
package pe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_A,
        S_CFG_K,
        S_CFG_IN,
        S_START,
        S_POLL,
        S_DRAIN
    } seq_state_t;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_KDIM   = 4'd2;
    localparam logic [3:0] REG_IDIM   = 4'd3;

    localparam int STATUS_DONE_BIT = 0;

    localparam int LANES  = 16;
    localparam int ACT_W  = 8;
    localparam int PSUM_W = 32;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Nested three-level counter (inner fastest). Wraps every level back to zero on
// the advance that consumes the final position, so it is ready for the next phase.
module pe_seq_addr_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         advance,
    input  logic [W-1:0] inner_lim,
    input  logic [W-1:0] mid_lim,
    input  logic [W-1:0] outer_lim,
    output logic [W-1:0] inner,
    output logic [W-1:0] mid,
    output logic [W-1:0] outer,
    output logic         inner_wrap,
    output logic         mid_wrap,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic outer_wrap;

    assign inner_wrap = (inner == inner_lim - ONE);
    assign mid_wrap   = (mid == mid_lim - ONE);
    assign outer_wrap = (outer == outer_lim - ONE);
    assign last       = inner_wrap && mid_wrap && outer_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner <= '0;
            mid   <= '0;
            outer <= '0;
        end else if (init) begin
            inner <= '0;
            mid   <= '0;
            outer <= '0;
        end else if (advance) begin
            if (inner_wrap) begin
                inner <= '0;
                if (mid_wrap) begin
                    mid   <= '0;
                    outer <= outer_wrap ? '0 : outer + ONE;
                end else begin
                    mid <= mid + ONE;
                end
            end else begin
                inner <= inner + ONE;
            end
        end
    end

endmodule

// File: rtl/pe_host_sequencer.sv
// Autonomous host sequencer for pe_top: loads weights and activations, programs
// and starts the PE, polls for completion and streams the psum buffer out.
module pe_host_sequencer
    import pe_seq_pkg::*;
#(
    parameter int MAX_COUT     = 16,
    parameter int POLL_TIMEOUT = 100000,
    parameter int RES_AW       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_start,
    input  logic [3:0]              cfg_kh,
    input  logic [3:0]              cfg_kw,
    input  logic [7:0]              cfg_in_h,
    input  logic [7:0]              cfg_in_w,
    input  logic [4:0]              cfg_cout,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*ACT_W-1:0]  s_data,
    output logic                    wb_we,
    output logic [15:0]             wb_addr,
    output logic [LANES*ACT_W-1:0]  wb_data,
    output logic                    ab_we,
    output logic [15:0]             ab_addr,
    output logic [LANES*ACT_W-1:0]  ab_data,
    output logic                    pe_cfg_we,
    output logic [3:0]              pe_cfg_addr,
    output logic [31:0]             pe_cfg_wdata,
    input  logic [31:0]             pe_cfg_rdata,
    output logic [RES_AW-1:0]       res_addr,
    input  logic [LANES*PSUM_W-1:0] res_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*PSUM_W-1:0] m_data,
    output logic                    m_last
);

    localparam int PCW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_TIMEOUT - 1);
    localparam logic [5:0]     COUT_MAX  = 6'(MAX_COUT);
    localparam logic [15:0]    W_STRIDE  = 16'(MAX_COUT);

    seq_state_t              state_reg;
    logic [3:0]              kh_reg, kw_reg;
    logic [7:0]              in_h_reg, in_w_reg;
    logic [4:0]              cout_reg;
    logic                    busy_reg, done_reg, err_reg;
    logic                    rd_pend_reg, m_valid_reg, m_last_reg;
    logic [PCW-1:0]          poll_cnt_reg;
    logic [LANES*PSUM_W-1:0] m_data_reg;

    logic        cfg_ok;
    logic [7:0]  out_h, out_w;
    logic [7:0]  lim_inner, lim_mid, lim_outer;
    logic        gen_init, gen_adv, gen_last;
    logic [7:0]  g_inner, g_mid, g_outer;
    logic [15:0] w_addr_calc, a_addr_calc;
    logic [1:0]  unused_wraps;
    logic        unused_rdata;

    assign cfg_ok = (cfg_kh != 4'd0) && (cfg_kw != 4'd0)
                 && ({4'd0, cfg_kh} <= cfg_in_h) && ({4'd0, cfg_kw} <= cfg_in_w)
                 && (cfg_cout != 5'd0) && ({1'b0, cfg_cout} <= COUT_MAX);

    assign out_h = in_h_reg - {4'd0, kh_reg} + 8'd1;
    assign out_w = in_w_reg - {4'd0, kw_reg} + 8'd1;

    // One counter serves every phase; only its limits change with the state.
    always_comb begin
        lim_inner = 8'd1;
        lim_mid   = 8'd1;
        lim_outer = 8'd1;
        case (state_reg)
            S_LOAD_W: begin
                lim_inner = {3'd0, cout_reg};
                lim_mid   = {4'd0, kw_reg};
                lim_outer = {4'd0, kh_reg};
            end
            S_LOAD_A: begin
                lim_inner = in_w_reg;
                lim_mid   = in_h_reg;
            end
            S_DRAIN: begin
                lim_inner = out_w;
                lim_mid   = out_h;
            end
            default: ;
        endcase
    end

    assign gen_init = (state_reg == S_IDLE);
    assign gen_adv  = (((state_reg == S_LOAD_W) || (state_reg == S_LOAD_A)) && s_valid)
                   || ((state_reg == S_DRAIN) && m_valid_reg && m_ready);

    pe_seq_addr_gen #(.W(8)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (gen_init),
        .advance    (gen_adv),
        .inner_lim  (lim_inner),
        .mid_lim    (lim_mid),
        .outer_lim  (lim_outer),
        .inner      (g_inner),
        .mid        (g_mid),
        .outer      (g_outer),
        .inner_wrap (unused_wraps[0]),
        .mid_wrap   (unused_wraps[1]),
        .last       (gen_last)
    );

    assign w_addr_calc = ({8'd0, g_outer} * {12'd0, kw_reg} + {8'd0, g_mid}) * W_STRIDE
                       + {8'd0, g_inner};
    assign a_addr_calc = {8'd0, g_mid} * {8'd0, in_w_reg} + {8'd0, g_inner};

    assign s_ready  = (state_reg == S_LOAD_W) || (state_reg == S_LOAD_A);
    assign wb_we    = (state_reg == S_LOAD_W) && s_valid;
    assign wb_addr  = (state_reg == S_LOAD_W) ? w_addr_calc : 16'd0;
    assign wb_data  = (state_reg == S_LOAD_W) ? s_data : '0;
    assign ab_we    = (state_reg == S_LOAD_A) && s_valid;
    assign ab_addr  = (state_reg == S_LOAD_A) ? a_addr_calc : 16'd0;
    assign ab_data  = (state_reg == S_LOAD_A) ? s_data : '0;
    assign res_addr = (state_reg == S_DRAIN) ? RES_AW'(a_addr_calc) : '0;

    always_comb begin
        pe_cfg_we    = 1'b0;
        pe_cfg_addr  = REG_CTRL;
        pe_cfg_wdata = 32'd0;
        case (state_reg)
            S_CFG_K: begin
                pe_cfg_we    = 1'b1;
                pe_cfg_addr  = REG_KDIM;
                pe_cfg_wdata = {20'd0, kh_reg, 4'd0, kw_reg};
            end
            S_CFG_IN: begin
                pe_cfg_we    = 1'b1;
                pe_cfg_addr  = REG_IDIM;
                pe_cfg_wdata = {16'd0, in_h_reg, in_w_reg};
            end
            S_START: begin
                pe_cfg_we    = 1'b1;
                pe_cfg_wdata = 32'd1;
            end
            S_POLL:  pe_cfg_addr = REG_STATUS;
            default: ;
        endcase
    end

    assign unused_rdata = ^pe_cfg_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            kh_reg       <= '0;
            kw_reg       <= '0;
            in_h_reg     <= '0;
            in_w_reg     <= '0;
            cout_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rd_pend_reg  <= 1'b0;
            m_valid_reg  <= 1'b0;
            m_last_reg   <= 1'b0;
            m_data_reg   <= '0;
            poll_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_start && !done_reg) begin
                        kh_reg   <= cfg_kh;
                        kw_reg   <= cfg_kw;
                        in_h_reg <= cfg_in_h;
                        in_w_reg <= cfg_in_w;
                        cout_reg <= cfg_cout;
                        if (cfg_ok) begin
                            busy_reg  <= 1'b1;
                            state_reg <= S_LOAD_W;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_LOAD_W: if (s_valid && gen_last) state_reg <= S_LOAD_A;
                S_LOAD_A: if (s_valid && gen_last) state_reg <= S_CFG_K;
                S_CFG_K:  state_reg <= S_CFG_IN;
                S_CFG_IN: state_reg <= S_START;
                S_START: begin
                    poll_cnt_reg <= '0;
                    state_reg    <= S_POLL;
                end
                S_POLL: begin
                    if (pe_cfg_rdata[STATUS_DONE_BIT]) begin
                        rd_pend_reg <= 1'b0;
                        state_reg   <= S_DRAIN;
                    end else if (poll_cnt_reg == POLL_LAST) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Issue address, wait one cycle for the buffer, capture, hold until taken.
                    if (m_valid_reg) begin
                        if (m_ready) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            if (m_last_reg) begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= S_IDLE;
                            end
                        end
                    end else if (rd_pend_reg) begin
                        m_data_reg  <= res_data;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= gen_last;
                        rd_pend_reg <= 1'b0;
                    end else begin
                        rd_pend_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_last  = m_last_reg;

endmodule

// File: tb/tb_pe_host_sequencer.sv
// Scoreboard bench for pe_host_sequencer with PE status and psum buffer stubs.
module tb_pe_host_sequencer;

    localparam int MAX_COUT     = 16;
    localparam int POLL_TIMEOUT = 64;
    localparam int RES_AW       = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_start = 1'b0;
    logic [3:0]   cfg_kh = '0, cfg_kw = '0;
    logic [7:0]   cfg_in_h = '0, cfg_in_w = '0;
    logic [4:0]   cfg_cout = '0;
    logic         busy, done, err;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         wb_we, ab_we, pe_cfg_we;
    logic [15:0]  wb_addr, ab_addr;
    logic [127:0] wb_data, ab_data;
    logic [3:0]   pe_cfg_addr;
    logic [31:0]  pe_cfg_wdata, pe_cfg_rdata;
    logic [RES_AW-1:0] res_addr;
    logic [511:0] res_data = '0;
    logic         m_valid, m_last;
    logic         m_ready = 1'b1;
    logic [511:0] m_data;

    pe_host_sequencer #(
        .MAX_COUT(MAX_COUT), .POLL_TIMEOUT(POLL_TIMEOUT), .RES_AW(RES_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
        .cfg_kh(cfg_kh), .cfg_kw(cfg_kw), .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w),
        .cfg_cout(cfg_cout), .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ab_we(ab_we), .ab_addr(ab_addr), .ab_data(ab_data),
        .pe_cfg_we(pe_cfg_we), .pe_cfg_addr(pe_cfg_addr), .pe_cfg_wdata(pe_cfg_wdata),
        .pe_cfg_rdata(pe_cfg_rdata), .res_addr(res_addr), .res_data(res_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] addr; logic [127:0] data; } wr_t;
    typedef struct packed { logic [3:0] addr; logic [31:0] data; } cfg_t;
    typedef struct packed { logic [511:0] data; logic last; } beat_t;

    wr_t   wq[$], aq[$];
    cfg_t  cq[$];
    beat_t oq[$];

    int n_vec = 0, n_miss = 0;
    int wb_cnt = 0, ab_cnt = 0, cfg_cnt = 0, beat_cnt = 0, done_cnt = 0, err_cnt = 0;
    int busy_cyc = 0, mvalid_cyc = 0;
    int b_wb, b_ab, b_cfg, b_beat, b_done, b_err, b_busy, b_mvalid;
    longint cyc = 0, t_poll = 0, t_err = 0;
    bit    poll_seen = 0;
    bit    ready_mode = 0;
    int    status_delay = -1;
    int    status_cnt = 0;
    logic  status_bit = 1'b0;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [511:0] pd = '0;

    function automatic logic [511:0] psum_of(input logic [RES_AW-1:0] a);
        logic [511:0] r;
        for (int l = 0; l < 16; l++) r[l*32 +: 32] = {6'd0, a, 12'h5A0, 4'(l)};
        return r;
    endfunction

    function automatic logic [127:0] beat_data(input int job, input int i);
        return {32'(job), 32'(i), 32'h5EED_0000 + 32'(i), ~32'(i)};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // PE and psum buffer stubs
    assign pe_cfg_rdata = (pe_cfg_addr == 4'd1) ? {31'd0, status_bit} : 32'h0;
    always @(posedge clk) res_data <= psum_of(res_addr);
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pe_cfg_we && pe_cfg_addr == 4'd0) begin
            status_cnt = 0;
            status_bit = 1'b0;
        end else begin
            status_cnt++;
            status_bit = (status_delay >= 0) && (status_cnt >= status_delay);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = ready_mode ? (cyc % 4 == 3) : 1'b1;
    end

    // Monitor: pops the scoreboard whenever the DUT strobes something.
    always @(negedge clk) begin
        wr_t w;
        cfg_t c;
        beat_t b;
        if (busy) busy_cyc++;
        if (m_valid) mvalid_cyc++;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            t_err = cyc;
        end
        if (busy && !pe_cfg_we && pe_cfg_addr == 4'd1 && !poll_seen) begin
            poll_seen = 1;
            t_poll = cyc;
        end
        if (wb_we) begin
            wb_cnt++;
            if (wq.size() == 0) unexpected("wb_write");
            else begin
                w = wq.pop_front();
                chk("wb_addr", 512'(wb_addr), 512'(w.addr));
                chk("wb_data", 512'(wb_data), 512'(w.data));
            end
        end
        if (ab_we) begin
            ab_cnt++;
            if (aq.size() == 0) unexpected("ab_write");
            else begin
                w = aq.pop_front();
                chk("ab_addr", 512'(ab_addr), 512'(w.addr));
                chk("ab_data", 512'(ab_data), 512'(w.data));
            end
        end
        if (pe_cfg_we) begin
            cfg_cnt++;
            if (cq.size() == 0) unexpected("cfg_write");
            else begin
                c = cq.pop_front();
                chk("cfg_addr", 512'(pe_cfg_addr), 512'(c.addr));
                chk("cfg_wdata", 512'(pe_cfg_wdata), 512'(c.data));
            end
        end
        if (pv && !pr) begin
            chk("m_hold_valid", 512'(m_valid), 512'(1'b1));
            chk("m_hold_data", m_data, pd);
            chk("m_hold_last", 512'(m_last), 512'(pl));
        end
        if (m_valid && m_ready) begin
            beat_cnt++;
            if (oq.size() == 0) unexpected("m_beat");
            else begin
                b = oq.pop_front();
                chk("m_data", m_data, b.data);
                chk("m_last", 512'(m_last), 512'(b.last));
            end
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
        pl = m_last;
    end

    task automatic snap();
        b_wb = wb_cnt; b_ab = ab_cnt; b_cfg = cfg_cnt; b_beat = beat_cnt;
        b_done = done_cnt; b_err = err_cnt; b_busy = busy_cyc; b_mvalid = mvalid_cyc;
    endtask

    task automatic check_deltas(input string tag, input int nwb, input int nab,
                                input int ncfg, input int nbeat, input int ndone, input int nerr);
        chk({tag, "_wb_count"}, 512'(wb_cnt - b_wb), 512'(nwb));
        chk({tag, "_ab_count"}, 512'(ab_cnt - b_ab), 512'(nab));
        chk({tag, "_cfg_count"}, 512'(cfg_cnt - b_cfg), 512'(ncfg));
        chk({tag, "_beat_count"}, 512'(beat_cnt - b_beat), 512'(nbeat));
        chk({tag, "_done_count"}, 512'(done_cnt - b_done), 512'(ndone));
        chk({tag, "_err_count"}, 512'(err_cnt - b_err), 512'(nerr));
        chk({tag, "_busy_end"}, 512'(busy), 512'(1'b0));
        chk({tag, "_queues_left"}, 512'(wq.size() + aq.size() + cq.size() + oq.size()), 512'(0));
    endtask

    task automatic send_beat(input logic [127:0] d);
        bit ok;
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!ok && g < 200);
        if (!ok) unexpected("s_ready_timeout");
    endtask

    task automatic run_job(input int job, input int kh, input int kw, input int ih, input int iw,
                           input int co, input bit toggle, input int sdelay, input bit rmode,
                           input int limit, input bit wait_end);
        int k = 0;
        int g = 0;
        int oh = ih - kh + 1;
        int ow = iw - kw + 1;
        int nb = kh * kw * co + ih * iw;
        status_delay = sdelay;
        ready_mode   = rmode;
        poll_seen    = 0;
        snap();
        for (int ky = 0; ky < kh; ky++)
            for (int kx = 0; kx < kw; kx++)
                for (int oc = 0; oc < co; oc++) begin
                    wq.push_back('{addr: 16'((ky * kw + kx) * MAX_COUT + oc), data: beat_data(job, k)});
                    k++;
                end
        for (int y = 0; y < ih; y++)
            for (int x = 0; x < iw; x++) begin
                aq.push_back('{addr: 16'(y * iw + x), data: beat_data(job, k)});
                k++;
            end
        cq.push_back('{addr: 4'd2, data: 32'(kh * 256 + kw)});
        cq.push_back('{addr: 4'd3, data: 32'(ih * 256 + iw)});
        cq.push_back('{addr: 4'd0, data: 32'd1});
        if (sdelay >= 0)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    oq.push_back('{data: psum_of(RES_AW'(oy * iw + ox)),
                                   last: (oy == oh - 1) && (ox == ow - 1)});
        cfg_kh = 4'(kh); cfg_kw = 4'(kw); cfg_in_h = 8'(ih); cfg_in_w = 8'(iw); cfg_cout = 5'(co);
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        if (limit < nb) nb = limit;
        for (int i = 0; i < nb; i++) begin
            if (toggle) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(beat_data(job, i));
        end
        s_valid = 1'b0;
        if (wait_end) begin
            do begin
                @(negedge clk);
                g++;
            end while (!(done || err) && g < 3000);
            if (g >= 3000) unexpected("job_end_timeout");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 512'({busy, done, err, s_ready, wb_we, ab_we, pe_cfg_we, m_valid, m_last}), 512'(0));
        chk({tag, "_addr"}, 512'({wb_addr, ab_addr, pe_cfg_addr, res_addr, pe_cfg_wdata}), 512'(0));
        chk({tag, "_wdata"}, 512'({wb_data, ab_data}), 512'(0));
        chk({tag, "_mdata"}, m_data, 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(1, 3, 3, 5, 5, 4, 0, 50, 1, 1000, 1);
        check_deltas("job_cont", 36, 25, 3, 9, 1, 0);

        run_job(2, 3, 3, 5, 5, 4, 1, 50, 1, 1000, 1);
        check_deltas("job_toggle", 36, 25, 3, 9, 1, 0);

        snap();
        cfg_kh = 4'd6; cfg_kw = 4'd3; cfg_in_h = 8'd5; cfg_in_w = 8'd5; cfg_cout = 5'd4;
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        @(negedge clk);
        chk("badcfg_err_pulse", 512'(err), 512'(1'b1));
        chk("badcfg_busy", 512'(busy), 512'(1'b0));
        repeat (5) @(posedge clk);
        #1;
        check_deltas("badcfg", 0, 0, 0, 0, 0, 1);
        chk("badcfg_busy_cycles", 512'(busy_cyc - b_busy), 512'(0));

        run_job(4, 1, 1, 2, 2, 1, 0, -1, 0, 1000, 1);
        check_deltas("timeout", 1, 4, 3, 0, 0, 1);
        chk("timeout_latency", 512'(t_err - t_poll), 512'(POLL_TIMEOUT));
        chk("timeout_no_mvalid", 512'(mvalid_cyc - b_mvalid), 512'(0));

        run_job(5, 3, 3, 5, 5, 4, 0, 50, 0, 36 + 5, 0);
        chk("midjob_ab_count", 512'(ab_cnt - b_ab), 512'(5));
        chk("midjob_in_load_a", 512'({busy, s_ready}), 512'(2'b11));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        wq.delete(); aq.delete(); cq.delete(); oq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(6, 3, 3, 5, 5, 4, 0, 50, 1, 1000, 1);
        check_deltas("after_reset", 36, 25, 3, 9, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
